ccx4_responder: RTL and testbench

Off-chip end of the 4-bit custom-instruction (CCX4) link driven by the SoC's FazyRV-CCX core, implemented on the team's FPGA test board. It deserializes two 32-bit source operands and an operation select, computes the selected function, and serializes the 32-bit result back with a response strobe. It serves as the reference coprocessor for silicon bring-up and as the bench model for SoC-level CCX tests.

---
 rtl/ccx4_pkg.sv | 31 +++
 rtl/ccx4_alu.sv | 23 ++
 rtl/ccx4_responder.sv | 143 ++++++++++++++
 tb/tb_ccx4_responder.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccx4_pkg.sv
// Shared types and constants for the CCX4 custom-instruction responder.
// The bit-reverse helper is kept here so the ALU stays a flat case statement.
package ccx4_pkg;

  localparam int CCX4_NIBBLES = 8;
  localparam int CCX4_W       = 32;

  typedef enum logic [1:0] {
    ADD  = 2'b00,
    XOR  = 2'b01,
    MINU = 2'b10,
    BREV = 2'b11
  } ccx4_sel_e;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    CALC,
    WAIT,
    SEND
  } ccx4_state_e;

  function automatic logic [CCX4_W-1:0] bit_reverse(input logic [CCX4_W-1:0] v);
    logic [CCX4_W-1:0] r;
    for (int i = 0; i < CCX4_W; i++) begin
      r[i] = v[CCX4_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/ccx4_alu.sv
// Combinational CCX4 function unit: add, xor, unsigned min, bit-reverse of A.
// All arithmetic wraps at 32 bits.
module ccx4_alu
  import ccx4_pkg::*;
(
  input  logic [1:0]        sel,
  input  logic [CCX4_W-1:0] a,
  input  logic [CCX4_W-1:0] b,
  output logic [CCX4_W-1:0] result
);

  always_comb begin
    result = '0;
    case (ccx4_sel_e'(sel))
      ADD:     result = a + b;
      XOR:     result = a ^ b;
      MINU:    result = (a < b) ? a : b;
      BREV:    result = bit_reverse(a);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/ccx4_responder.sv
// Off-chip end of the CCX4 link: deserializes two operands nibble by nibble,
// computes the selected function and serializes the result back with a strobe.
module ccx4_responder
  import ccx4_pkg::*;
#(
  parameter int LATENCY = 0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ccx4_req_i,
  input  logic [1:0] ccx4_sel_i,
  input  logic [3:0] ccx4_rs_a_i,
  input  logic [3:0] ccx4_rs_b_i,
  output logic       ccx4_resp_o,
  output logic [3:0] ccx4_res_o
);

  localparam int                CNT_W     = $clog2(CCX4_NIBBLES);
  localparam logic [CNT_W-1:0]  LAST_NIB  = CNT_W'(CCX4_NIBBLES - 1);
  localparam logic [3:0]        WAIT_LOAD = 4'(LATENCY - 1);

  ccx4_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        wait_q, wait_d;
  ccx4_sel_e         sel_q;
  logic [CCX4_W-1:0] a_q, b_q;
  logic [CCX4_W-1:0] res_sr_q;
  logic [CCX4_W-1:0] alu_res;
  logic [CCX4_W-1:0] nib_src;
  logic              load_nib;
  logic              resp_q;
  logic [3:0]        res_q;

  ccx4_alu u_alu (
    .sel    (sel_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_res)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE: begin
        if (ccx4_req_i) begin
          state_d = RECV;
          cnt_d   = CNT_W'(1);
        end
      end
      RECV: begin
        if (!ccx4_req_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LAST_NIB) begin
          state_d = CALC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CALC: begin
        if (LATENCY == 0) begin
          state_d = SEND;
        end else begin
          state_d = WAIT;
          wait_d  = WAIT_LOAD;
        end
      end
      WAIT: begin
        if (wait_q == '0) state_d = SEND;
        else              wait_d  = wait_q - 4'd1;
      end
      SEND: begin
        if (cnt_q == LAST_NIB) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        wait_d  = '0;
      end
    endcase
  end

  // Output flops are loaded one cycle ahead of SEND so the strobe itself is registered.
  assign load_nib = (state_d == SEND);
  assign nib_src  = (state_q == CALC) ? alu_res : res_sr_q;

  // NOTE: sequential state uses non-blocking assignments only; the async reset clears every register, operands included.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wait_q   <= '0;
      sel_q    <= ADD;
      a_q      <= '0;
      b_q      <= '0;
      res_sr_q <= '0;
      resp_q   <= 1'b0;
      res_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;

      if (state_q == IDLE && ccx4_req_i) begin
        a_q   <= CCX4_W'(ccx4_rs_a_i);
        b_q   <= CCX4_W'(ccx4_rs_b_i);
        sel_q <= ccx4_sel_e'(ccx4_sel_i);
      end else if (state_q == RECV) begin
        if (ccx4_req_i) begin
          a_q[{cnt_q, 2'b00} +: 4] <= ccx4_rs_a_i;
          b_q[{cnt_q, 2'b00} +: 4] <= ccx4_rs_b_i;
        end else begin
          a_q   <= '0;
          b_q   <= '0;
          sel_q <= ADD;
        end
      end

      if (load_nib) begin
        resp_q   <= 1'b1;
        res_q    <= nib_src[3:0];
        res_sr_q <= nib_src >> 4;
      end else begin
        resp_q <= 1'b0;
        res_q  <= '0;
        if (state_q == CALC) res_sr_q <= alu_res;
      end
    end
  end

  assign ccx4_resp_o = resp_q;
  assign ccx4_res_o  = res_q;

endmodule

// File: tb/tb_ccx4_responder.sv
// Directed bench for ccx4_responder: one instance with LATENCY=0 and one with LATENCY=3,
// each driven from per-cycle stimulus tables; expected results are hand-computed constants.
module tb_ccx4_responder;

  logic       clk;
  logic       rst;
  logic       req_v  [2];
  logic [1:0] sel_v  [2];
  logic [3:0] a_v    [2];
  logic [3:0] b_v    [2];
  logic       resp_v [2];
  logic [3:0] res_v  [2];

  int total = 0;
  int bad   = 0;

  logic       st_req [64];
  logic [1:0] st_sel [64];
  logic [3:0] st_a   [64];
  logic [3:0] st_b   [64];
  logic       ob_resp[64];
  logic [3:0] ob_res [64];
  int         leak;
  logic       mid_resp;
  logic [3:0] mid_res;

  ccx4_responder #(.LATENCY(0)) u_lat0 (
    .clk_i       (clk),
    .rst_i       (rst),
    .ccx4_req_i  (req_v[0]),
    .ccx4_sel_i  (sel_v[0]),
    .ccx4_rs_a_i (a_v[0]),
    .ccx4_rs_b_i (b_v[0]),
    .ccx4_resp_o (resp_v[0]),
    .ccx4_res_o  (res_v[0])
  );

  ccx4_responder #(.LATENCY(3)) u_lat3 (
    .clk_i       (clk),
    .rst_i       (rst),
    .ccx4_req_i  (req_v[1]),
    .ccx4_sel_i  (sel_v[1]),
    .ccx4_rs_a_i (a_v[1]),
    .ccx4_rs_b_i (b_v[1]),
    .ccx4_resp_o (resp_v[1]),
    .ccx4_res_o  (res_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_stim();
    for (int c = 0; c < 64; c++) begin
      st_req[c] = 1'b0;
      st_sel[c] = 2'b00;
      st_a[c]   = 4'h0;
      st_b[c]   = 4'h0;
    end
  endtask

  // Lays out nibbles 0..nnib-1 of a transaction starting at cycle 'start'.
  task automatic load_txn(input int start, input logic [1:0] sel0, input logic [1:0] sel_rest,
                          input logic [31:0] a, input logic [31:0] b, input int nnib);
    for (int k = 0; k < nnib; k++) begin
      st_req[start+k] = 1'b1;
      st_sel[start+k] = (k == 0) ? sel0 : sel_rest;
      st_a[start+k]   = a[4*k +: 4];
      st_b[start+k]   = b[4*k +: 4];
    end
  endtask

  // Plays the stimulus table into instance d for n cycles, sampling outputs mid-cycle.
  task automatic run(input int d, input int n, input int rst_cyc);
    leak = 0;
    @(posedge clk); #1;
    for (int c = 0; c < n; c++) begin
      req_v[d] = st_req[c];
      sel_v[d] = st_sel[c];
      a_v[d]   = st_a[c];
      b_v[d]   = st_b[c];
      if (c == rst_cyc) begin
        #1 rst = 1'b1;
        #1 mid_resp = resp_v[d];
        mid_res = res_v[d];
        #1 rst = 1'b0;
      end
      @(negedge clk);
      ob_resp[c] = resp_v[d];
      ob_res[c]  = res_v[d];
      if (!resp_v[d] && res_v[d] !== 4'h0) leak++;
      @(posedge clk); #1;
    end
    req_v[d] = 1'b0;
    sel_v[d] = 2'b00;
    a_v[d]   = 4'h0;
    b_v[d]   = 4'h0;
  endtask

  task automatic extract(input int first, output logic [31:0] val, output int cnt,
                         output logic pre, output logic post);
    val = '0;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      val[4*k +: 4] = ob_res[first+k];
      if (ob_resp[first+k] === 1'b1) cnt++;
    end
    pre  = ob_resp[first-1];
    post = ob_resp[first+8];
  endtask

  function automatic int count_resp(input int lo, input int hi);
    int n = 0;
    for (int c = lo; c <= hi; c++) if (ob_resp[c] !== 1'b0) n++;
    return n;
  endfunction

  task automatic test_reset();
    #3;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (resp_v[d] !== 1'b0 || res_v[d] !== 4'h0) begin
        bad++;
        $display("FAIL reset_hold[%0d]: resp=%b res=%h, want 0/0", d, resp_v[d], res_v[d]);
      end
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (resp_v[d] !== 1'b0 || res_v[d] !== 4'h0) begin
        bad++;
        $display("FAIL reset_release[%0d]: resp=%b res=%h, want 0/0", d, resp_v[d], res_v[d]);
      end
    end
  endtask

  task automatic test_xor();
    logic [31:0] val; int cnt; logic pre, post;
    clear_stim();
    load_txn(0, 2'b01, 2'b01, 32'h12345678, 32'hFFFF0000, 8);
    run(0, 24, -1);
    extract(9, val, cnt, pre, post);
    total++;
    if (val !== 32'hEDCB5678) begin bad++; $display("FAIL xor_val: got %h want EDCB5678", val); end
    total++;
    if (cnt !== 8 || pre !== 1'b0 || post !== 1'b0) begin
      bad++; $display("FAIL xor_strobe: cnt=%0d pre=%b post=%b want 8/0/0", cnt, pre, post);
    end
    total++;
    if (leak !== 0) begin bad++; $display("FAIL xor_idle_res: nonzero res while idle %0d times want 0", leak); end
  endtask

  task automatic test_add_wrap();
    logic [31:0] val; int cnt; logic pre, post;
    clear_stim();
    load_txn(0,  2'b00, 2'b00, 32'h00000001, 32'hFFFFFFFF, 8);
    load_txn(17, 2'b00, 2'b00, 32'h0000000F, 32'h00000001, 8);
    run(0, 40, -1);
    extract(9, val, cnt, pre, post);
    total++;
    if (val !== 32'h00000000 || cnt !== 8 || pre !== 1'b0 || post !== 1'b0) begin
      bad++; $display("FAIL add_wrap: val=%h cnt=%0d pre=%b post=%b want 00000000/8/0/0", val, cnt, pre, post);
    end
    extract(26, val, cnt, pre, post);
    total++;
    if (val !== 32'h00000010 || cnt !== 8 || pre !== 1'b0 || post !== 1'b0) begin
      bad++; $display("FAIL add_carry: val=%h cnt=%0d pre=%b post=%b want 00000010/8/0/0", val, cnt, pre, post);
    end
  endtask

  task automatic test_latency();
    logic [31:0] val; int cnt; logic pre, post;
    clear_stim();
    load_txn(0,  2'b10, 2'b10, 32'h80000000, 32'h7FFFFFFF, 8);
    load_txn(20, 2'b11, 2'b11, 32'h00000001, 32'hDEADBEEF, 8);
    run(1, 45, -1);
    extract(12, val, cnt, pre, post);
    total++;
    if (val !== 32'h7FFFFFFF) begin bad++; $display("FAIL minu_val: got %h want 7FFFFFFF", val); end
    total++;
    if (cnt !== 8 || pre !== 1'b0 || post !== 1'b0 || count_resp(0, 11) !== 0) begin
      bad++; $display("FAIL minu_timing: cnt=%0d pre=%b post=%b early=%0d want 8/0/0/0",
                      cnt, pre, post, count_resp(0, 11));
    end
    extract(32, val, cnt, pre, post);
    total++;
    if (val !== 32'h80000000 || cnt !== 8 || pre !== 1'b0 || post !== 1'b0) begin
      bad++; $display("FAIL brev: val=%h cnt=%0d pre=%b post=%b want 80000000/8/0/0", val, cnt, pre, post);
    end
  endtask

  task automatic test_abort();
    logic [31:0] val; int cnt; logic pre, post;
    clear_stim();
    load_txn(0,  2'b00, 2'b00, 32'h11111111, 32'h22222222, 5);
    load_txn(36, 2'b01, 2'b01, 32'hA5A5A5A5, 32'h0F0F0F0F, 8);
    run(0, 60, -1);
    total++;
    if (count_resp(0, 35) !== 0) begin
      bad++; $display("FAIL abort_quiet: resp high %0d cycles want 0", count_resp(0, 35));
    end
    extract(45, val, cnt, pre, post);
    total++;
    if (val !== 32'hAAAAAAAA || cnt !== 8 || pre !== 1'b0 || post !== 1'b0) begin
      bad++; $display("FAIL abort_next: val=%h cnt=%0d pre=%b post=%b want AAAAAAAA/8/0/0", val, cnt, pre, post);
    end
  endtask

  task automatic test_sel_change();
    logic [31:0] val; int cnt; logic pre, post;
    clear_stim();
    load_txn(0, 2'b00, 2'b00, 32'h0000F0F0, 32'h00001111, 8);
    for (int k = 3; k < 8; k++) st_sel[k] = 2'b01;
    run(0, 24, -1);
    extract(9, val, cnt, pre, post);
    total++;
    if (val !== 32'h00010201 || cnt !== 8) begin
      bad++; $display("FAIL sel_change: val=%h cnt=%0d want 00010201/8", val, cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] val; int cnt; logic pre, post;
    clear_stim();
    load_txn(0, 2'b00, 2'b00, 32'h10000000, 32'h20000000, 8);
    for (int c = 8; c < 17; c++) begin
      st_req[c] = 1'b1;
      st_sel[c] = 2'b11;
      st_a[c]   = 4'hF;
      st_b[c]   = 4'hF;
    end
    load_txn(17, 2'b01, 2'b01, 32'hFFFFFFFF, 32'h0F0F0F0F, 8);
    run(0, 40, -1);
    extract(9, val, cnt, pre, post);
    total++;
    if (val !== 32'h30000000 || cnt !== 8 || pre !== 1'b0 || post !== 1'b0) begin
      bad++; $display("FAIL held_first: val=%h cnt=%0d pre=%b post=%b want 30000000/8/0/0", val, cnt, pre, post);
    end
    extract(26, val, cnt, pre, post);
    total++;
    if (val !== 32'hF0F0F0F0 || cnt !== 8 || pre !== 1'b0 || post !== 1'b0) begin
      bad++; $display("FAIL held_second: val=%h cnt=%0d pre=%b post=%b want F0F0F0F0/8/0/0", val, cnt, pre, post);
    end
  endtask

  task automatic test_reset_mid_send();
    logic [31:0] val; int cnt; logic pre, post;
    clear_stim();
    load_txn(0,  2'b00, 2'b00, 32'h87654321, 32'h00000000, 8);
    load_txn(30, 2'b01, 2'b01, 32'h00000000, 32'h13579BDF, 8);
    run(0, 50, 12);
    total++;
    if ({ob_res[11], ob_res[10], ob_res[9]} !== 12'h321 || count_resp(9, 11) !== 3) begin
      bad++; $display("FAIL rst_prefix: nibbles=%h%h%h cnt=%0d want 321/3",
                      ob_res[11], ob_res[10], ob_res[9], count_resp(9, 11));
    end
    total++;
    if (mid_resp !== 1'b0 || mid_res !== 4'h0) begin
      bad++; $display("FAIL rst_async: resp=%b res=%h want 0/0 before any edge", mid_resp, mid_res);
    end
    total++;
    if (count_resp(12, 38) !== 0) begin
      bad++; $display("FAIL rst_quiet: resp high %0d cycles want 0", count_resp(12, 38));
    end
    extract(39, val, cnt, pre, post);
    total++;
    if (val !== 32'h13579BDF || cnt !== 8 || post !== 1'b0) begin
      bad++; $display("FAIL rst_next: val=%h cnt=%0d post=%b want 13579BDF/8/0", val, cnt, post);
    end
  endtask

  initial begin
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_v[d] = 1'b0;
      sel_v[d] = 2'b00;
      a_v[d]   = 4'h0;
      b_v[d]   = 4'h0;
    end
    #2 rst = 1'b1;
    test_reset();
    test_xor();
    test_add_wrap();
    test_latency();
    test_abort();
    test_sel_change();
    test_back_to_back();
    test_reset_mid_send();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
